apb_gpio_regs: RTL and testbench

- APB slave register block directly downstream of the Wishbone-to-APB bridge. It consumes the bridge's s_apb_* outputs and drives s_apb_rdata / s_apb_rready back to it.
- Provides a GPIO expander: output data, direction, synchronized input, edge-detect interrupts with W1C status, and an ID register.
- Timing matches the bridge's fixed protocol:
  - Setup cycle: sel=1, ena=0.
  - Access cycle: sel=1, ena=1. The bridge acks the Wishbone master in this cycle.
  - There are no wait states.

---
 rtl/apb_gpio_regs.sv | 185 ++++++++++++++++++
 tb/tb_apb_gpio_regs.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_regs.sv
// ---------------------------------------------------------------------------
// apb_gpio_regs
// APB slave GPIO expander sitting behind the Wishbone-to-APB bridge.
// Registers: DATA_OUT, DIR, DATA_IN (synchronized pads), IRQ_EN,
// IRQ_STATUS (W1C, edge-set), EDGE_SEL (1 = rising), ID.
//
// Ports:
//   wb_clk_i, wb_rst_n_i   clock / async active-low reset
//   s_apb_addr/sel/write/ena/wdata/pstb   APB request from the bridge
//   s_apb_rdata            registered read data (captured in setup cycle)
//   s_apb_rready           PREADY, 1 whenever out of reset
//   gpio_in                asynchronous pad inputs
//   gpio_out, gpio_oe      DATA_OUT and DIR register contents
//   irq_o                  registered |(IRQ_STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
module apb_gpio_regs #(
   parameter int unsigned NGPIO     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ID_VALUE  = 32'h4750_494F
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic [31:0]      s_apb_addr,
   input  logic             s_apb_sel,
   input  logic             s_apb_write,
   input  logic             s_apb_ena,
   input  logic [31:0]      s_apb_wdata,
   input  logic [3:0]       s_apb_pstb,
   output logic [31:0]      s_apb_rdata,
   output logic             s_apb_rready,
   input  logic [NGPIO-1:0] gpio_in,
   output logic [NGPIO-1:0] gpio_out,
   output logic [NGPIO-1:0] gpio_oe,
   output logic             irq_o
);

   localparam int unsigned OFF_W = 6;
   localparam logic [OFF_W-1:0] OFF_DATA_OUT   = 6'h00;
   localparam logic [OFF_W-1:0] OFF_DIR        = 6'h01;
   localparam logic [OFF_W-1:0] OFF_DATA_IN    = 6'h02;
   localparam logic [OFF_W-1:0] OFF_IRQ_EN     = 6'h03;
   localparam logic [OFF_W-1:0] OFF_IRQ_STATUS = 6'h04;
   localparam logic [OFF_W-1:0] OFF_EDGE_SEL   = 6'h05;
   localparam logic [OFF_W-1:0] OFF_ID         = 6'h06;

   // State
   logic [NGPIO-1:0] data_out_q,   data_out_d;
   logic [NGPIO-1:0] dir_q,        dir_d;
   logic [NGPIO-1:0] irq_en_q,     irq_en_d;
   logic [NGPIO-1:0] irq_status_q, irq_status_d;
   logic [NGPIO-1:0] edge_sel_q,   edge_sel_d;
   logic [NGPIO-1:0] meta_q,       meta_d;
   logic [NGPIO-1:0] sync_q,       sync_d;
   logic [NGPIO-1:0] prev_q,       prev_d;
   logic [1:0]       warm_q,       warm_d;
   logic [31:0]      rdata_q,      rdata_d;
   logic             irq_q,        irq_d;
   logic             rready_q,     rready_d;

   // Decode helpers
   logic             base_hit;
   logic [OFF_W-1:0] offset;
   logic             wr_en;
   logic             rd_cap;
   logic [31:0]      lane_mask;
   logic [NGPIO-1:0] wmask;
   logic [NGPIO-1:0] wbits;
   logic [NGPIO-1:0] edge_hit;
   logic [31:0]      rd_val;

   // Address decode, byte-lane mask and read mux
   always_comb begin
      base_hit = (s_apb_addr[31:8] == BASE_ADDR[31:8]);
      offset   = s_apb_addr[7:2];
      wr_en    = s_apb_sel & s_apb_ena & s_apb_write & base_hit;
      rd_cap   = s_apb_sel & ~s_apb_ena & ~s_apb_write;
      lane_mask = '0;
      for (int k = 0; k < 4; k++) begin
         lane_mask[8*k +: 8] = {8{s_apb_pstb[k]}};
      end
      wmask = lane_mask[NGPIO-1:0];
      wbits = s_apb_wdata[NGPIO-1:0];

      rd_val = '0;
      if (base_hit) begin
         case (offset)
            OFF_DATA_OUT:   rd_val = 32'(data_out_q);
            OFF_DIR:        rd_val = 32'(dir_q);
            OFF_DATA_IN:    rd_val = 32'(sync_q);
            OFF_IRQ_EN:     rd_val = 32'(irq_en_q);
            OFF_IRQ_STATUS: rd_val = 32'(irq_status_q);
            OFF_EDGE_SEL:   rd_val = 32'(edge_sel_q);
            OFF_ID:         rd_val = ID_VALUE;
            default:        rd_val = '0;
         endcase
      end
   end

   // Edge detect, gated until the warm-up counter saturates so pins already
   // high at reset release do not look like rising edges.
   always_comb begin
      edge_hit = '0;
      if (warm_q == 2'd3) begin
         edge_hit = (edge_sel_q & sync_q & ~prev_q) |
                    (~edge_sel_q & ~sync_q & prev_q);
      end
   end

   // Next-state logic
   always_comb begin
      data_out_d   = data_out_q;
      dir_d        = dir_q;
      irq_en_d     = irq_en_q;
      irq_status_d = irq_status_q;
      edge_sel_d   = edge_sel_q;
      rdata_d      = rdata_q;

      meta_d   = gpio_in;
      sync_d   = meta_q;
      prev_d   = sync_q;
      warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      rready_d = 1'b1;

      if (wr_en) begin
         case (offset)
            OFF_DATA_OUT: data_out_d = (data_out_q & ~wmask) | (wbits & wmask);
            OFF_DIR:      dir_d      = (dir_q      & ~wmask) | (wbits & wmask);
            OFF_IRQ_EN:   irq_en_d   = (irq_en_q   & ~wmask) | (wbits & wmask);
            OFF_EDGE_SEL: edge_sel_d = (edge_sel_q & ~wmask) | (wbits & wmask);
            OFF_IRQ_STATUS: irq_status_d = irq_status_q & ~(wbits & wmask);
            default: ;
         endcase
      end
      // Set after clear so a same-cycle edge wins over W1C
      irq_status_d = irq_status_d | edge_hit;

      if (rd_cap) begin
         rdata_d = rd_val;
      end

      irq_d = |(irq_status_q & irq_en_q);
   end

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         data_out_q   <= '0;
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_status_q <= '0;
         edge_sel_q   <= '0;
         meta_q       <= '0;
         sync_q       <= '0;
         prev_q       <= '0;
         warm_q       <= '0;
         rdata_q      <= '0;
         irq_q        <= 1'b0;
         rready_q     <= 1'b0;
      end else begin
         data_out_q   <= data_out_d;
         dir_q        <= dir_d;
         irq_en_q     <= irq_en_d;
         irq_status_q <= irq_status_d;
         edge_sel_q   <= edge_sel_d;
         meta_q       <= meta_d;
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         warm_q       <= warm_d;
         rdata_q      <= rdata_d;
         irq_q        <= irq_d;
         rready_q     <= rready_d;
      end
   end

   assign s_apb_rdata  = rdata_q;
   assign s_apb_rready = rready_q;
   assign gpio_out     = data_out_q;
   assign gpio_oe      = dir_q;
   assign irq_o        = irq_q;

   // Address byte bits and write data / lane bits above NGPIO are don't-care
   logic unused_bits;
   assign unused_bits = ^{s_apb_addr[1:0], s_apb_wdata, lane_mask};

endmodule

// File: tb/tb_apb_gpio_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_gpio_regs
// Directed scoreboard bench for apb_gpio_regs: expected values are queued
// as stimulus is issued and popped when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_apb_gpio_regs;

   localparam int unsigned NGPIO = 16;
   localparam logic [31:0] A_DATA_OUT   = 32'h3000_0000;
   localparam logic [31:0] A_DIR        = 32'h3000_0004;
   localparam logic [31:0] A_DATA_IN    = 32'h3000_0008;
   localparam logic [31:0] A_IRQ_EN     = 32'h3000_000C;
   localparam logic [31:0] A_IRQ_STATUS = 32'h3000_0010;
   localparam logic [31:0] A_EDGE_SEL   = 32'h3000_0014;
   localparam logic [31:0] A_ID         = 32'h3000_0018;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      addr;
   logic             sel;
   logic             wr;
   logic             ena;
   logic [31:0]      wdata;
   logic [3:0]       pstb;
   logic [31:0]      rdata;
   logic             rready;
   logic [NGPIO-1:0] gpio_in;
   logic [NGPIO-1:0] gpio_out;
   logic [NGPIO-1:0] gpio_oe;
   logic             irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   apb_gpio_regs #(
      .NGPIO     (NGPIO),
      .BASE_ADDR (32'h3000_0000),
      .ID_VALUE  (32'h4750_494F)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_n_i   (rst_n),
      .s_apb_addr   (addr),
      .s_apb_sel    (sel),
      .s_apb_write  (wr),
      .s_apb_ena    (ena),
      .s_apb_wdata  (wdata),
      .s_apb_pstb   (pstb),
      .s_apb_rdata  (rdata),
      .s_apb_rready (rready),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .gpio_oe      (gpio_oe),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $fatal(1, "FAIL watchdog: simulation did not finish (%0d checks, %0d errors)",
             n_checks, n_errors);
   end

   task automatic push(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
      push(tag, e);
      pop_chk(obs);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apb_idle();
      sel = 1'b0; ena = 1'b0; wr = 1'b0;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      sel = 1'b1; ena = 1'b0; wr = 1'b1; addr = a; wdata = d; pstb = s;
      @(posedge clk); #1;
      ena = 1'b1;
      @(posedge clk); #1;
      apb_idle();
   endtask

   // Expected value queued at setup, compared in the access cycle
   task automatic apb_read(input string tag, input logic [31:0] a, input logic [31:0] e);
      push(tag, e);
      @(posedge clk); #1;
      sel = 1'b1; ena = 1'b0; wr = 1'b0; addr = a;
      @(posedge clk); #1;
      ena = 1'b1;
      pop_chk(rdata);
      @(posedge clk); #1;
      apb_idle();
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; wdata = '0; pstb = '0;
      sel = 1'b0; ena = 1'b0; wr = 1'b0;
      gpio_in = 16'h3C00;

      // Reset state
      #3;
      chk("rst_rdata",  rdata,            32'h0);
      chk("rst_rready", 32'(rready),      32'h0);
      chk("rst_irq",    32'(irq),         32'h0);
      chk("rst_gpio_out", 32'(gpio_out),  32'h0);
      tick(2);
      @(negedge clk); rst_n = 1'b1;
      tick(1);
      chk("rready_after_rst", 32'(rready), 32'h1);
      apb_read("id", A_ID, 32'h4750_494F);
      chk("rready_run", 32'(rready),   32'h1);
      chk("gpio_out_0", 32'(gpio_out), 32'h0);
      chk("gpio_oe_0",  32'(gpio_oe),  32'h0);

      // Byte-lane writes
      apb_write(A_DATA_OUT, 32'h0000_A5A5, 4'b0001);
      chk("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);
      apb_read("data_out_a5", A_DATA_OUT, 32'h0000_00A5);
      apb_write(A_DATA_OUT, 32'h0000_FFFF, 4'b0000);
      apb_read("data_out_pstb0", A_DATA_OUT, 32'h0000_00A5);
      apb_write(A_DATA_OUT, 32'h5A5A_1200, 4'b1110);
      apb_read("data_out_lane1", A_DATA_OUT, 32'h0000_12A5);
      apb_write(A_DIR, 32'hFFFF_0F0F, 4'b1111);
      chk("gpio_oe_0f0f", 32'(gpio_oe), 32'h0000_0F0F);
      apb_read("dir_0f0f", A_DIR, 32'h0000_0F0F);
      apb_write(A_DATA_IN, 32'h0000_FFFF, 4'b1111);
      apb_read("data_in_ro", A_DATA_IN, 32'h0000_3C00);

      // Rising edge on bit 0: status 3 cycles after the pin, irq one later
      apb_write(A_IRQ_EN, 32'h1, 4'b1111);
      apb_write(A_EDGE_SEL, 32'h1, 4'b1111);
      gpio_in[0] = 1'b1;
      tick(1); chk("irq_e1", 32'(irq), 32'h0);
      tick(1); chk("irq_e2", 32'(irq), 32'h0);
      tick(1); chk("irq_e3", 32'(irq), 32'h0);
      tick(1); chk("irq_e4", 32'(irq), 32'h1);
      apb_read("status_set", A_IRQ_STATUS, 32'h1);
      apb_write(A_IRQ_STATUS, 32'h1, 4'b1111);
      chk("irq_at_w1c", 32'(irq), 32'h1);
      tick(1);
      chk("irq_after_w1c", 32'(irq), 32'h0);
      apb_read("status_clr", A_IRQ_STATUS, 32'h0);

      // Set/clear collision: set wins
      gpio_in[0] = 1'b0; tick(4);
      gpio_in[0] = 1'b1; tick(5);
      chk("irq_pre_collide", 32'(irq), 32'h1);
      gpio_in[0] = 1'b0; tick(4);
      gpio_in[0] = 1'b1;
      apb_write(A_IRQ_STATUS, 32'h1, 4'b1111);
      chk("irq_collide0", 32'(irq), 32'h1);
      tick(1);
      chk("irq_collide1", 32'(irq), 32'h1);
      apb_read("status_collide", A_IRQ_STATUS, 32'h1);
      apb_write(A_IRQ_STATUS, 32'h1, 4'b1111);
      tick(1);
      apb_read("status_clr2", A_IRQ_STATUS, 32'h0);

      // Warm-up suppression: pins high through reset, EDGE_SEL written at once
      rst_n = 1'b0;
      gpio_in = 16'hFFFF;
      sel = 1'b1; ena = 1'b0; wr = 1'b1; addr = A_EDGE_SEL; wdata = 32'h0000_FFFF; pstb = 4'hF;
      tick(2);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; ena = 1'b1;
      @(posedge clk); #1; apb_idle();
      apb_write(A_IRQ_EN, 32'h0000_FFFF, 4'b1111);
      tick(3);
      chk("irq_warm", 32'(irq), 32'h0);
      apb_read("edge_sel_ff",  A_EDGE_SEL,   32'h0000_FFFF);
      apb_read("status_warm",  A_IRQ_STATUS, 32'h0);
      apb_read("data_in_ff",   A_DATA_IN,    32'h0000_FFFF);
      apb_read("data_out_rst", A_DATA_OUT,   32'h0);
      apb_read("unmapped",     32'h3000_0040, 32'h0);
      apb_read("base_miss",    32'h3100_0000, 32'h0);
      apb_write(32'h3100_0000, 32'h0000_FFFF, 4'b1111);
      apb_write(32'h3000_0040, 32'h0000_FFFF, 4'b1111);
      apb_read("data_out_miss", A_DATA_OUT, 32'h0);

      // Falling edge on bit 1 to raise irq before the aborted write
      apb_write(A_EDGE_SEL, 32'h0, 4'b1111);
      gpio_in[1] = 1'b0;
      tick(4);
      chk("irq_fall", 32'(irq), 32'h1);
      apb_write(A_DATA_OUT, 32'h0000_0F0F, 4'b1111);
      chk("gpio_out_0f0f", 32'(gpio_out), 32'h0000_0F0F);
      apb_read("id2", A_ID, 32'h4750_494F);
      apb_write(A_DIR, 32'h0000_00FF, 4'b1111);
      tick(1);
      chk("rdata_hold", rdata, 32'h4750_494F);

      // Access without setup: read keeps old rdata, write still commits
      @(posedge clk); #1;
      sel = 1'b1; ena = 1'b1; wr = 1'b0; addr = A_DATA_OUT;
      @(posedge clk); #1; apb_idle();
      chk("rdata_noset", rdata, 32'h4750_494F);
      @(posedge clk); #1;
      sel = 1'b1; ena = 1'b1; wr = 1'b1; addr = A_DIR; wdata = 32'h0000_0055; pstb = 4'hF;
      @(posedge clk); #1; apb_idle();
      chk("gpio_oe_noset", 32'(gpio_oe), 32'h0000_0055);

      // Reset during access cycle of DATA_OUT write
      @(posedge clk); #1;
      sel = 1'b1; ena = 1'b0; wr = 1'b1; addr = A_DATA_OUT; wdata = 32'h0000_FFFF; pstb = 4'hF;
      @(posedge clk); #1;
      ena = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_rdata",    rdata,           32'h0);
      chk("abort_irq",      32'(irq),        32'h0);
      chk("abort_gpio_out", 32'(gpio_out),   32'h0);
      chk("abort_rready",   32'(rready),     32'h0);
      apb_idle();
      tick(2);
      @(negedge clk); rst_n = 1'b1;
      tick(4);
      apb_read("abort_data_out", A_DATA_OUT, 32'h0);
      chk("abort_gpio_out2", 32'(gpio_out), 32'h0);
      chk("abort_irq2",      32'(irq),      32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
